// File: rtl/bit_skip_ctrl_if.sv
// ----------------------------------------------------------------------------
// bit_skip_ctrl_if
//   Bundle between the decoder / bit processor / PC-fetch unit and the
//   skip/branch sequencer (bit_skip_ctrl).
//
//   Decoder side -> sequencer:
//     idc_sbic..idc_brbc  one-hot decoded bit-test instruction in execute
//     bit_test_op_out     condition result (1 = skip/branch taken)
//     next_instr          prefetched word following the current instruction
//     brb_offset          signed 7-bit word offset of BRBS/BRBC
//     pc                  address of the next instruction (current PC+1)
//   Sequencer -> fetch/PC/interrupt logic:
//     flush               replace instruction register with NOP
//     pc_load, pc_new     branch target load
//     irq_inhibit         block interrupt acceptance
//     skip_busy           sequencer not idle
//
//   modport master : the core side that drives decode results
//   modport slave  : the sequencer
// ----------------------------------------------------------------------------
interface bit_skip_ctrl_if #(
    parameter int PC_W = 16
);
    logic            idc_sbic;
    logic            idc_sbis;
    logic            idc_sbrs;
    logic            idc_sbrc;
    logic            idc_brbs;
    logic            idc_brbc;
    logic            bit_test_op_out;
    logic [15:0]     next_instr;
    logic [6:0]      brb_offset;
    logic [PC_W-1:0] pc;

    logic            flush;
    logic            pc_load;
    logic [PC_W-1:0] pc_new;
    logic            irq_inhibit;
    logic            skip_busy;

    modport master (
        output idc_sbic, idc_sbis, idc_sbrs, idc_sbrc, idc_brbs, idc_brbc,
        output bit_test_op_out, next_instr, brb_offset, pc,
        input  flush, pc_load, pc_new, irq_inhibit, skip_busy
    );

    modport slave (
        input  idc_sbic, idc_sbis, idc_sbrs, idc_sbrc, idc_brbs, idc_brbc,
        input  bit_test_op_out, next_instr, brb_offset, pc,
        output flush, pc_load, pc_new, irq_inhibit, skip_busy
    );
endinterface

// File: rtl/bit_skip_ctrl.sv
// ----------------------------------------------------------------------------
// bit_skip_ctrl
//   Sequences the skip or branch resulting from SBIC/SBIS/SBRS/SBRC/BRBS/BRBC
//   once the bit processor has evaluated the condition:
//     - skips flush one instruction word (two for LDS/STS/JMP/CALL)
//     - taken relative branches reload the PC and flush the fetched word
//     - interrupts are inhibited while a skip or branch is in flight
//
//   Ports:
//     cp2     core clock
//     ireset  asynchronous active-low reset
//     cp2en   clock enable; state and outputs only advance when 1
//     bus     bit_skip_ctrl_if.slave (decode inputs, flush/PC/irq outputs)
// ----------------------------------------------------------------------------
module bit_skip_ctrl #(
    parameter int PC_W = 16
) (
    input  logic            cp2,
    input  logic            ireset,
    input  logic            cp2en,
    bit_skip_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SKIP1    = 2'd1,
        SKIP2    = 2'd2,
        BR_TAKEN = 2'd3
    } state_t;

    state_t          state;
    logic            two_word;
    logic [PC_W-1:0] pc_new_q;
    logic            flush_q;
    logic            pc_load_q;
    logic            busy_q;

    logic            is_branch;
    logic            is_skip;
    logic            next_is_two_word;
    logic [PC_W-1:0] branch_target;

    assign is_branch = bus.idc_brbs | bus.idc_brbc;
    assign is_skip   = bus.idc_sbic | bus.idc_sbis | bus.idc_sbrs | bus.idc_sbrc;

    // LDS/STS (1001 00xd dddd 0000) and JMP/CALL (1001 010k kkkk 11xk) carry a
    // second word that must be flushed as well.
    assign next_is_two_word = ((bus.next_instr & 16'hFC0F) == 16'h9000) ||
                              ((bus.next_instr & 16'hFE0C) == 16'h940C);

    // Target arithmetic wraps naturally at PC_W bits.
    assign branch_target = bus.pc + {{(PC_W-7){bus.brb_offset[6]}}, bus.brb_offset};

    // Outputs are flops that are loaded together with the state, so they are
    // always exactly the decode of the current state and glitch-free.
    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            state     <= IDLE;
            two_word  <= 1'b0;
            pc_new_q  <= '0;
            flush_q   <= 1'b0;
            pc_load_q <= 1'b0;
            busy_q    <= 1'b0;
        end else if (cp2en) begin
            // NOTE: defaults first, overridden below; with non-blocking
            // assignments the last one executed in the block wins.
            flush_q   <= 1'b0;
            pc_load_q <= 1'b0;
            busy_q    <= 1'b0;

            case (state)
                IDLE: begin
                    // A branch strobe owns the decision even if a skip strobe
                    // is also (erroneously) present.
                    if (is_branch) begin
                        if (bus.bit_test_op_out) begin
                            state     <= BR_TAKEN;
                            pc_new_q  <= branch_target;
                            flush_q   <= 1'b1;
                            pc_load_q <= 1'b1;
                            busy_q    <= 1'b1;
                        end
                    end else if (is_skip && bus.bit_test_op_out) begin
                        state    <= SKIP1;
                        two_word <= next_is_two_word;
                        flush_q  <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end

                SKIP1: begin
                    if (two_word) begin
                        state   <= SKIP2;
                        flush_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end

                SKIP2:    state <= IDLE;
                BR_TAKEN: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    assign bus.flush       = flush_q;
    assign bus.pc_load     = pc_load_q;
    assign bus.pc_new      = pc_new_q;
    assign bus.irq_inhibit = busy_q;
    assign bus.skip_busy   = busy_q;

endmodule

// File: tb/tb_bit_skip_ctrl.sv
// ----------------------------------------------------------------------------
// tb_bit_skip_ctrl
//   Self-checking bench for bit_skip_ctrl. Each scenario task drives one
//   cycle at a time and pushes the outputs expected for that cycle into a
//   scoreboard queue; a monitor pops and compares on every falling edge.
// ----------------------------------------------------------------------------
module tb_bit_skip_ctrl;

    typedef struct {
        logic        flush;
        logic        pc_load;
        logic        busy;
        logic        chk_pc;
        logic [15:0] pc_new;
    } exp_t;

    logic  cp2;
    logic  ireset;
    logic  cp2en;
    int    chk_cnt  = 0;
    int    pass_cnt = 0;
    bit    mon_en   = 0;
    string cur_test = "none";
    exp_t  sb[$];
    exp_t  mon_e;

    bit_skip_ctrl_if #(.PC_W(16)) bus ();

    bit_skip_ctrl #(.PC_W(16)) dut (
        .cp2    (cp2),
        .ireset (ireset),
        .cp2en  (cp2en),
        .bus    (bus)
    );

    initial cp2 = 1'b0;
    always #5 cp2 = ~cp2;

    // Scoreboard consumer: outputs are sampled mid-cycle.
    always @(negedge cp2) begin
        if (mon_en && sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk_cnt++;
            if ({bus.flush, bus.pc_load, bus.skip_busy, bus.irq_inhibit} !==
                    {mon_e.flush, mon_e.pc_load, mon_e.busy, mon_e.busy} ||
                (mon_e.chk_pc && bus.pc_new !== mon_e.pc_new)) begin
                $display("FAIL %s @%0t: flush/pc_load/busy/irq=%b%b%b%b pc_new=%h, expected %b%b%b%b pc_new=%h",
                         cur_test, $time, bus.flush, bus.pc_load, bus.skip_busy,
                         bus.irq_inhibit, bus.pc_new, mon_e.flush, mon_e.pc_load,
                         mon_e.busy, mon_e.busy, mon_e.pc_new);
            end else begin
                pass_cnt++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Push the expectation for the current cycle, then advance one cycle.
    task automatic cyc(input logic f, input logic pl, input logic b,
                       input logic cp, input logic [15:0] pn);
        exp_t e;
        e.flush   = f;
        e.pc_load = pl;
        e.busy    = b;
        e.chk_pc  = cp;
        e.pc_new  = pn;
        sb.push_back(e);
        @(posedge cp2);
        #1;
    endtask

    task automatic clr_strobes();
        bus.idc_sbic        = 1'b0;
        bus.idc_sbis        = 1'b0;
        bus.idc_sbrs        = 1'b0;
        bus.idc_sbrc        = 1'b0;
        bus.idc_brbs        = 1'b0;
        bus.idc_brbc        = 1'b0;
        bus.bit_test_op_out = 1'b0;
    endtask

    task automatic test_reset();
        cur_test = "reset";
        ireset = 1'b1;
        cp2en  = 1'b1;
        clr_strobes();
        bus.next_instr = 16'h0000;
        bus.brb_offset = 7'h00;
        bus.pc         = 16'h0000;
        #3 ireset = 1'b0;
        #2;
        chk_cnt++;
        if ({bus.flush, bus.pc_load, bus.skip_busy, bus.irq_inhibit} !== 4'b0000 ||
            bus.pc_new !== 16'h0000) begin
            $display("FAIL reset_values: outputs=%b pc_new=%h, expected 0000 pc_new=0000",
                     {bus.flush, bus.pc_load, bus.skip_busy, bus.irq_inhibit}, bus.pc_new);
        end else begin
            pass_cnt++;
        end
        // Strobes during reset must be ignored.
        bus.idc_brbs = 1'b1;
        bus.bit_test_op_out = 1'b1;
        bus.brb_offset = 7'h01;
        @(posedge cp2);
        #1;
        chk_cnt++;
        if ({bus.flush, bus.pc_load, bus.skip_busy, bus.irq_inhibit} !== 4'b0000 ||
            bus.pc_new !== 16'h0000) begin
            $display("FAIL reset_held: outputs=%b pc_new=%h, expected 0000 pc_new=0000",
                     {bus.flush, bus.pc_load, bus.skip_busy, bus.irq_inhibit}, bus.pc_new);
        end else begin
            pass_cnt++;
        end
        clr_strobes();
        @(negedge cp2);
        ireset = 1'b1;
        @(posedge cp2);
        #1;
        mon_en = 1;
    endtask

    // SBRS over a one-word instruction; the strobe is left high during SKIP1
    // to confirm it is ignored outside IDLE.
    task automatic test_skip_one_word();
        cur_test = "skip_1word";
        bus.idc_sbrs = 1'b1;
        bus.bit_test_op_out = 1'b1;
        bus.next_instr = 16'h0C01;
        cyc(0, 0, 0, 0, 16'h0);
        cyc(1, 0, 1, 0, 16'h0);
        clr_strobes();
        cyc(0, 0, 0, 0, 16'h0);
        cyc(0, 0, 0, 0, 16'h0);
    endtask

    task automatic test_skip_two_word(input logic [15:0] instr, input string name);
        cur_test = name;
        bus.idc_sbic = 1'b1;
        bus.bit_test_op_out = 1'b1;
        bus.next_instr = instr;
        cyc(0, 0, 0, 0, 16'h0);
        clr_strobes();
        bus.next_instr = 16'h0000;
        cyc(1, 0, 1, 0, 16'h0);
        cyc(1, 0, 1, 0, 16'h0);
        cyc(0, 0, 0, 0, 16'h0);
    endtask

    task automatic test_branch(input logic use_brbs, input logic [15:0] pc,
                               input logic [6:0] off, input logic [15:0] target,
                               input string name);
        cur_test = name;
        bus.idc_brbs = use_brbs;
        bus.idc_brbc = ~use_brbs;
        bus.bit_test_op_out = 1'b1;
        bus.pc = pc;
        bus.brb_offset = off;
        cyc(0, 0, 0, 0, 16'h0);
        clr_strobes();
        bus.pc = 16'hDEAD;          // target must have been captured already
        bus.brb_offset = 7'h00;
        cyc(1, 1, 1, 1, target);
        cyc(0, 0, 0, 1, target);
    endtask

    task automatic test_cond_false();
        cur_test = "cond_false";
        bus.next_instr = 16'h940C;
        bus.pc = 16'h1234;
        bus.brb_offset = 7'h03;
        for (int i = 0; i < 6; i++) begin
            clr_strobes();
            case (i)
                0: bus.idc_sbic = 1'b1;
                1: bus.idc_sbis = 1'b1;
                2: bus.idc_sbrs = 1'b1;
                3: bus.idc_sbrc = 1'b1;
                4: bus.idc_brbs = 1'b1;
                default: bus.idc_brbc = 1'b1;
            endcase
            bus.bit_test_op_out = 1'b0;
            cyc(0, 0, 0, 0, 16'h0);
            clr_strobes();
            cyc(0, 0, 0, 0, 16'h0);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] pc_v;
        logic [6:0]  off_v;
        logic [15:0] target;
        cur_test = "back_to_back";
        pc_v  = 16'h2000;
        off_v = 7'h7F;              // -1
        target = pc_v + {{9{off_v[6]}}, off_v};
        bus.idc_sbrc = 1'b1;
        bus.bit_test_op_out = 1'b1;
        bus.next_instr = 16'h0000;
        cyc(0, 0, 0, 0, 16'h0);
        clr_strobes();
        cyc(1, 0, 1, 0, 16'h0);
        // Back in IDLE: branch decision in this very cycle.
        bus.idc_brbc = 1'b1;
        bus.bit_test_op_out = 1'b1;
        bus.pc = pc_v;
        bus.brb_offset = off_v;
        cyc(0, 0, 0, 0, 16'h0);
        clr_strobes();
        cyc(1, 1, 1, 1, target);
        cyc(0, 0, 0, 1, target);
    endtask

    // Branch plus skip strobe together: branch wins (one flush with pc_load,
    // not a two-word skip).
    task automatic test_priority();
        cur_test = "priority";
        bus.idc_brbs = 1'b1;
        bus.idc_sbis = 1'b1;
        bus.bit_test_op_out = 1'b1;
        bus.next_instr = 16'h940C;
        bus.pc = 16'h0010;
        bus.brb_offset = 7'h10;
        cyc(0, 0, 0, 0, 16'h0);
        clr_strobes();
        cyc(1, 1, 1, 1, 16'h0020);
        cyc(0, 0, 0, 1, 16'h0020);
    endtask

    task automatic test_freeze_and_reset();
        exp_t e;
        cur_test = "freeze";
        bus.idc_sbis = 1'b1;
        bus.bit_test_op_out = 1'b1;
        bus.next_instr = 16'h9200;  // STS: two words
        cyc(0, 0, 0, 0, 16'h0);
        clr_strobes();
        bus.next_instr = 16'h0000;
        cp2en = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 1, 16'h0020);
        cp2en = 1'b1;
        cyc(1, 0, 1, 1, 16'h0020);  // SKIP1 -> SKIP2
        cur_test = "reset_mid_skip2";
        e.flush = 1'b1; e.pc_load = 1'b0; e.busy = 1'b1; e.chk_pc = 1'b0; e.pc_new = 16'h0;
        sb.push_back(e);
        @(negedge cp2);
        #1 ireset = 1'b0;
        #1;
        chk_cnt++;
        if ({bus.flush, bus.pc_load, bus.skip_busy, bus.irq_inhibit} !== 4'b0000 ||
            bus.pc_new !== 16'h0000) begin
            $display("FAIL async_reset: outputs=%b pc_new=%h, expected 0000 pc_new=0000",
                     {bus.flush, bus.pc_load, bus.skip_busy, bus.irq_inhibit}, bus.pc_new);
        end else begin
            pass_cnt++;
        end
        @(posedge cp2);
        #1 ireset = 1'b1;
        cyc(0, 0, 0, 1, 16'h0000);
        cur_test = "after_reset";
        bus.idc_sbrs = 1'b1;
        bus.bit_test_op_out = 1'b1;
        bus.next_instr = 16'h0C01;
        cyc(0, 0, 0, 0, 16'h0);
        clr_strobes();
        cyc(1, 0, 1, 0, 16'h0);
        cyc(0, 0, 0, 0, 16'h0);
    endtask

    initial begin
        test_reset();
        test_skip_one_word();
        test_skip_two_word(16'h940C, "skip_jmp");
        test_skip_two_word(16'h9200, "skip_sts");
        test_branch(1'b1, 16'h0100, 7'h40, 16'h00C0, "brbs_back");
        test_branch(1'b0, 16'hFFFE, 7'h05, 16'h0003, "brbc_wrap");
        test_cond_false();
        test_back_to_back();
        test_priority();
        test_freeze_and_reset();
        @(negedge cp2);
        #1;
        chk_cnt++;
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end else begin
            pass_cnt++;
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
